// File: rtl/period_meter.sv
// period_meter: counts clk cycles between rising edges of the asynchronous sig_in and
// delivers each period on a valid/ready output. `define GLITCH_FILTER_EN drops pulses < 3 cycles.
module period_meter #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             counter_reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [WIDTH-1:0] meas_data,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             meas_ovf,
   output logic             dropped,
   input  logic             dropped_clr
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE,
      ARMED
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   edge_det;
   logic [WIDTH-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       period;
   logic                   ovf_pend_q, ovf_pend_d;
   logic                   publish;
   logic                   slot_free;

   // NOTE: every clocked process uses non-blocking (<=) so all flops sample the same pre-edge values.
   always_ff @(posedge clk or posedge counter_reset) begin
      if (counter_reset) sync_q <= '0;
      else               sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q, filt_d;

   // The filtered level only follows s once s has matched its two previous samples.
   always_comb begin
      filt_d = filt_q;
      if (s == hist_q[0] && s == hist_q[1]) filt_d = s;
   end

   always_ff @(posedge clk or posedge counter_reset) begin
      if (counter_reset) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], s};
         filt_q <= filt_d;
      end
   end

   assign edge_det = filt_d & ~filt_q;
`else
   logic s_prev_q;

   always_ff @(posedge clk or posedge counter_reset) begin
      if (counter_reset) s_prev_q <= 1'b0;
      else               s_prev_q <= s;
   end

   assign edge_det = s & ~s_prev_q;
`endif

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      publish    = 1'b0;
      period     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + WIDTH'(1);
      case (state_q)
         IDLE: begin
            cnt_d      = '0;
            ovf_pend_d = 1'b0;
            if (enable && edge_det) state_d = ARMED;
         end
         ARMED: begin
            if (!enable) begin
               state_d    = IDLE;
               cnt_d      = '0;
               ovf_pend_d = 1'b0;
            end else if (edge_det) begin
               publish    = 1'b1;
               cnt_d      = '0;
               ovf_pend_d = 1'b0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + WIDTH'(1);
               if (cnt_d == CNT_MAX) ovf_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge counter_reset) begin
      if (counter_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
      end
   end

   // The output slot accepts a new period if empty or being emptied in this same cycle.
   assign slot_free = ~meas_valid | meas_ready;

   always_ff @(posedge clk or posedge counter_reset) begin
      if (counter_reset) begin
         meas_data  <= '0;
         meas_valid <= 1'b0;
         meas_ovf   <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         if (publish && slot_free) begin
            meas_data  <= period;
            meas_ovf   <= ovf_pend_q;
            meas_valid <= 1'b1;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end

         if (publish && !slot_free) dropped <= 1'b1;
         else if (dropped_clr)      dropped <= 1'b0;
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: a 32-bit and a 4-bit instance share stimulus; expected periods
// come from the gaps between the rising edges the bench itself drives on sig_in.
`timescale 1ns/1ps
module tb_period_meter;

   localparam int SYNC = 2;
`ifdef GLITCH_FILTER_EN
   localparam int LAT       = SYNC + 3;
   localparam int MIN_LVL   = 3;
   localparam int SHORT_GAP = 6;
`else
   localparam int LAT       = SYNC + 1;
   localparam int MIN_LVL   = 1;
   localparam int SHORT_GAP = 5;
`endif
   localparam int W4_MAX = 15;

   typedef struct {
      int unsigned data;
      bit          ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        counter_reset = 1'b1;
   logic        enable = 1'b0;
   logic        sig_in = 1'b0;
   logic        meas_ready = 1'b0;
   logic        dropped_clr = 1'b0;
   logic [31:0] d32;
   logic        v32, o32, dr32;
   logic [3:0]  d4;
   logic        v4, o4, dr4;

   res_t got32[$], got4[$], exp32[$], exp4[$];
   int   gaps[$], highs[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   vld_cycles = 0;

   always #5 clk = ~clk;

   period_meter #(.WIDTH(32), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .counter_reset(counter_reset), .enable(enable), .sig_in(sig_in),
      .meas_data(d32), .meas_valid(v32), .meas_ready(meas_ready), .meas_ovf(o32),
      .dropped(dr32), .dropped_clr(dropped_clr)
   );

   period_meter #(.WIDTH(4), .SYNC_STAGES(SYNC)) dut_w4 (
      .clk(clk), .counter_reset(counter_reset), .enable(enable), .sig_in(sig_in),
      .meas_data(d4), .meas_valid(v4), .meas_ready(meas_ready), .meas_ovf(o4),
      .dropped(dr4), .dropped_clr(dropped_clr)
   );

   // Transfers are observed on the falling edge, midway between active edges.
   always @(negedge clk) begin
      if (!counter_reset) begin
         if (v32 && meas_ready) got32.push_back('{data: d32, ovf: o32});
         if (v4 && meas_ready)  got4.push_back('{data: 32'(d4), ovf: o4});
         if (v32) vld_cycles++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected normal completion");
      $fatal(1, "watchdog");
   end

   // Reference: a P-cycle gap reports P; a 4-bit meter saturates at 15 and flags overflow.
   function automatic void expect_period(input int p);
      exp32.push_back('{data: p, ovf: 1'b0});
      exp4.push_back('{data: (p > W4_MAX) ? W4_MAX : p, ovf: (p > W4_MAX)});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input int gap, input int high);
      sig_in = 1'b1;
      repeat (high) tick();
      sig_in = 1'b0;
      repeat (gap - high) tick();
   endtask

   // Drives one rise per entry of gaps; every gap except the last is followed by a rise.
   task automatic run_train();
      for (int i = 0; i < gaps.size(); i++) begin
         if (i < gaps.size() - 1) expect_period(gaps[i]);
         pulse(gaps[i], highs[i]);
      end
   endtask

   task automatic set_train(input int n, input int gap);
      gaps.delete();
      highs.delete();
      for (int i = 0; i < n; i++) begin
         gaps.push_back(gap);
         highs.push_back(gap / 2);
      end
   endtask

   task automatic end_test();
      sig_in     = 1'b0;
      enable     = 1'b0;
      meas_ready = 1'b1;
      idle(LAT + 4);
      got32.delete(); got4.delete(); exp32.delete(); exp4.delete();
   endtask

   task automatic test_reset();
      idle(2);
      n_cmp++;
      if ({d32, v32, o32, dr32} !== '0) begin
         n_err++;
         $display("FAIL reset w32: got data=%0d valid=%b ovf=%b dropped=%b, expected all 0", d32, v32, o32, dr32);
      end
      n_cmp++;
      if ({d4, v4, o4, dr4} !== '0) begin
         n_err++;
         $display("FAIL reset w4: got data=%0d valid=%b ovf=%b dropped=%b, expected all 0", d4, v4, o4, dr4);
      end
      counter_reset = 1'b0;
      idle(2);
   endtask

   task automatic test_square();
      enable = 1'b1; meas_ready = 1'b1; vld_cycles = 0;
      set_train(5, 10);
      run_train();
      idle(LAT + 3);
      n_cmp++;
      if (got32.size() != exp32.size() || got4.size() != exp4.size()) begin
         n_err++;
         $display("FAIL square count: got %0d/%0d results, expected %0d", got32.size(), got4.size(), exp32.size());
      end else foreach (exp32[i]) begin
         n_cmp++;
         if (got32[i].data !== exp32[i].data || got32[i].ovf !== exp32[i].ovf ||
             got4[i].data !== exp4[i].data || got4[i].ovf !== exp4[i].ovf) begin
            n_err++;
            $display("FAIL square[%0d]: got %0d/%b (w4 %0d/%b), expected %0d/%b (w4 %0d/%b)", i,
                     got32[i].data, got32[i].ovf, got4[i].data, got4[i].ovf,
                     exp32[i].data, exp32[i].ovf, exp4[i].data, exp4[i].ovf);
         end
      end
      n_cmp++;
      if (vld_cycles != 4) begin
         n_err++;
         $display("FAIL square valid_cycles: got %0d, expected 4", vld_cycles);
      end
      end_test();
   endtask

   task automatic test_saturation();
      enable = 1'b1; meas_ready = 1'b1;
      gaps = '{20, SHORT_GAP, 10};
      highs = '{10, SHORT_GAP / 2, 5};
      run_train();
      idle(LAT + 3);
      n_cmp++;
      if (got32.size() != exp32.size() || got4.size() != exp4.size()) begin
         n_err++;
         $display("FAIL saturation count: got %0d/%0d results, expected %0d", got32.size(), got4.size(), exp32.size());
      end else foreach (exp32[i]) begin
         n_cmp++;
         if (got32[i].data !== exp32[i].data || got32[i].ovf !== exp32[i].ovf ||
             got4[i].data !== exp4[i].data || got4[i].ovf !== exp4[i].ovf) begin
            n_err++;
            $display("FAIL saturation[%0d]: got %0d/%b (w4 %0d/%b), expected %0d/%b (w4 %0d/%b)", i,
                     got32[i].data, got32[i].ovf, got4[i].data, got4[i].ovf,
                     exp32[i].data, exp32[i].ovf, exp4[i].data, exp4[i].ovf);
         end
      end
      end_test();
   endtask

   task automatic test_random();
      enable = 1'b1; meas_ready = 1'b1;
      gaps.delete();
      highs.delete();
      for (int i = 0; i < 14; i++) begin
         int g;
         g = int'($urandom_range(6, 30));
         gaps.push_back(g);
         highs.push_back(int'($urandom_range(MIN_LVL, g - MIN_LVL)));
      end
      run_train();
      idle(LAT + 3);
      n_cmp++;
      if (got32.size() != exp32.size() || got4.size() != exp4.size()) begin
         n_err++;
         $display("FAIL random count: got %0d/%0d results, expected %0d", got32.size(), got4.size(), exp32.size());
      end else foreach (exp32[i]) begin
         n_cmp++;
         if (got32[i].data !== exp32[i].data || got32[i].ovf !== exp32[i].ovf ||
             got4[i].data !== exp4[i].data || got4[i].ovf !== exp4[i].ovf) begin
            n_err++;
            $display("FAIL random[%0d]: got %0d/%b (w4 %0d/%b), expected %0d/%b (w4 %0d/%b)", i,
                     got32[i].data, got32[i].ovf, got4[i].data, got4[i].ovf,
                     exp32[i].data, exp32[i].ovf, exp4[i].data, exp4[i].ovf);
         end
      end
      end_test();
   endtask

   task automatic test_drop();
      enable = 1'b1; meas_ready = 1'b0;
      set_train(3, 8);
      run_train();
      idle(LAT + 3);
      n_cmp++;
      if (v32 !== 1'b1 || d32 !== 32'd8 || dr32 !== 1'b1 || v4 !== 1'b1 || d4 !== 4'd8 || dr4 !== 1'b1) begin
         n_err++;
         $display("FAIL drop held: got valid=%b data=%0d dropped=%b (w4 %b/%0d/%b), expected 1/8/1",
                  v32, d32, dr32, v4, d4, dr4);
      end
      meas_ready = 1'b1;
      tick();
      meas_ready = 1'b0;
      idle(2);
      n_cmp++;
      if (got32.size() != 1 || v32 !== 1'b0 || dr32 !== 1'b1) begin
         n_err++;
         $display("FAIL drop transfer: got %0d transfers valid=%b dropped=%b, expected 1 transfer valid=0 dropped=1",
                  got32.size(), v32, dr32);
      end else begin
         n_cmp++;
         if (got32[0].data !== 8) begin
            n_err++;
            $display("FAIL drop transfer data: got %0d, expected 8", got32[0].data);
         end
      end
      dropped_clr = 1'b1;
      tick();
      dropped_clr = 1'b0;
      n_cmp++;
      if (dr32 !== 1'b0 || dr4 !== 1'b0) begin
         n_err++;
         $display("FAIL drop clear: got dropped=%b/%b, expected 0", dr32, dr4);
      end
      end_test();
   endtask

   task automatic test_back_to_back();
      enable = 1'b1; meas_ready = 1'b0;
      pulse(8, 4);
      pulse(9, 4);
      // Raise ready only at the clock edge that publishes the 9-cycle period.
      for (int c = 0; c < 12; c++) begin
         sig_in     = (c < 5);
         meas_ready = (c == LAT - 1);
         tick();
      end
      n_cmp++;
      if (got32.size() != 1 || v32 !== 1'b1 || d32 !== 32'd9 || dr32 !== 1'b0 || d4 !== 4'd9 || dr4 !== 1'b0) begin
         n_err++;
         $display("FAIL back_to_back: got %0d transfers valid=%b data=%0d dropped=%b (w4 %0d/%b), expected 1/1/9/0",
                  got32.size(), v32, d32, dr32, d4, dr4);
      end else begin
         n_cmp++;
         if (got32[0].data !== 8) begin
            n_err++;
            $display("FAIL back_to_back first: got %0d, expected 8", got32[0].data);
         end
      end
      end_test();
   endtask

   task automatic test_reset_mid();
      enable = 1'b1; meas_ready = 1'b0;
      set_train(3, 10);
      run_train();
      idle(3);
      counter_reset = 1'b1;
      #1;
      n_cmp++;
      if ({d32, v32, o32, dr32} !== '0 || {d4, v4, o4, dr4} !== '0) begin
         n_err++;
         $display("FAIL reset_mid: got data=%0d valid=%b ovf=%b dropped=%b (w4 %0d), expected all 0",
                  d32, v32, o32, dr32, d4);
      end
      idle(2);
      counter_reset = 1'b0;
      meas_ready = 1'b1;
      got32.delete(); got4.delete(); exp32.delete(); exp4.delete();
      idle(3);
      set_train(2, 12);
      run_train();
      idle(LAT + 3);
      n_cmp++;
      if (got32.size() != 1 || got4.size() != 1) begin
         n_err++;
         $display("FAIL reset_mid count: got %0d/%0d results, expected 1", got32.size(), got4.size());
      end else begin
         n_cmp++;
         if (got32[0].data !== 12 || got4[0].data !== 12 || got32[0].ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid period: got %0d (w4 %0d), expected 12", got32[0].data, got4[0].data);
         end
      end
      end_test();
   endtask

   task automatic test_disable();
      enable = 1'b0; meas_ready = 1'b1;
      set_train(4, 10);
      for (int i = 0; i < 4; i++) pulse(10, 5);
      idle(LAT + 3);
      n_cmp++;
      if (got32.size() != 0) begin
         n_err++;
         $display("FAIL disable idle: got %0d results, expected 0", got32.size());
      end
      enable = 1'b1; meas_ready = 1'b0;
      pulse(10, 5);
      pulse(10, 5);
      idle(LAT + 3);
      enable = 1'b0;
      idle(3);
      n_cmp++;
      if (v32 !== 1'b1 || d32 !== 32'd10) begin
         n_err++;
         $display("FAIL disable keep: got valid=%b data=%0d, expected 1/10", v32, d32);
      end
      meas_ready = 1'b1;
      idle(2);
      enable = 1'b1;
      pulse(7, 3);
      pulse(7, 3);
      idle(LAT + 3);
      n_cmp++;
      if (got32.size() != 2) begin
         n_err++;
         $display("FAIL disable rearm count: got %0d transfers, expected 2", got32.size());
      end else begin
         n_cmp++;
         if (got32[0].data !== 10 || got32[1].data !== 7) begin
            n_err++;
            $display("FAIL disable rearm data: got %0d,%0d, expected 10,7", got32[0].data, got32[1].data);
         end
      end
      end_test();
   endtask

   task automatic test_glitch();
      enable = 1'b1; meas_ready = 1'b1;
      // Period 10: high 3, low 3, 1-cycle pulse, low 3.
      for (int r = 0; r < 4; r++) begin
         sig_in = 1'b1; idle(3);
         sig_in = 1'b0; idle(3);
         sig_in = 1'b1; idle(1);
         sig_in = 1'b0; idle(3);
      end
      idle(LAT + 3);
`ifdef GLITCH_FILTER_EN
      for (int i = 0; i < 3; i++) expect_period(10);
`else
      for (int i = 0; i < 7; i++) expect_period((i % 2 == 0) ? 6 : 4);
`endif
      n_cmp++;
      if (got32.size() != exp32.size()) begin
         n_err++;
         $display("FAIL glitch count: got %0d results, expected %0d", got32.size(), exp32.size());
      end else foreach (exp32[i]) begin
         n_cmp++;
         if (got32[i].data !== exp32[i].data || got4[i].data !== exp4[i].data) begin
            n_err++;
            $display("FAIL glitch[%0d]: got %0d (w4 %0d), expected %0d", i, got32[i].data, got4[i].data, exp32[i].data);
         end
      end
      end_test();
   endtask

   initial begin
      test_reset();
      test_square();
      test_saturation();
      test_random();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      test_disable();
      test_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
